// File: rtl/display_trace_fifo.sv
// Queues writes to one watched register and steps through them on a debounced button or a fixed period.
// Capture is accepted the edge it is seen; data changes on the edge an advance fires; full-FIFO captures drop and latch overflow.
module display_trace_fifo #(
    parameter int         DEPTH           = 8,
    parameter logic [3:0] WATCH_REG       = 4'd11,
    parameter int         DEBOUNCE_CYCLES = 50000,
    parameter int         AUTO_PERIOD     = 50000000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     RegWrite,
    input  logic [3:0]               Rd,
    input  logic [31:0]              RegDisplay,
    input  logic                     step_btn,
    input  logic                     auto_mode,
    output logic [15:0]              data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     overflow
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW  = $clog2(AUTO_PERIOD + 1);

    localparam logic [CW-1:0]  FULL_COUNT = CW'(DEPTH);
    localparam logic [DBW-1:0] DB_LAST    = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0]  TMR_LAST   = TW'(AUTO_PERIOD - 1);

    logic [15:0]    mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;

    logic           sync1;
    logic           sync2;
    logic           db_level;
    logic [DBW-1:0] db_cnt;
    logic           db_hit;

    logic [TW-1:0]  timer;
    logic           auto_q;

    logic           full;
    logic           push;
    logic           pop;
    logic           accept;
    logic           adv;
    logic           adv_btn;
    logic           adv_timer;

    logic           unused_hi;
    assign unused_hi = ^RegDisplay[31:16];

    assign empty  = (count == '0);
    assign full   = (count == FULL_COUNT);
    assign push   = RegWrite && (Rd == WATCH_REG);
    assign pop    = adv && !empty;
    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign accept = push && (!full || pop);

    assign db_hit    = (sync2 != db_level) && (db_cnt == DB_LAST);
    assign adv_btn   = db_hit && !db_level;
    assign adv_timer = auto_mode && (auto_mode == auto_q) && (timer == TMR_LAST);
    assign adv       = auto_mode ? adv_timer : adv_btn;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            db_level <= 1'b0;
            db_cnt   <= '0;
        end else begin
            sync1 <= step_btn;
            sync2 <= sync1;
            if (sync2 == db_level) begin
                db_cnt <= '0;
            end else if (db_hit) begin
                db_level <= ~db_level;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // Timer only runs while there is something to show in auto mode; a mode flip restarts it.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer  <= '0;
            auto_q <= 1'b0;
        end else begin
            auto_q <= auto_mode;
            if ((auto_mode != auto_q) || !auto_mode || empty) begin
                timer <= '0;
            end else if (timer == TMR_LAST) begin
                timer <= '0;
            end else begin
                timer <= timer + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && accept) begin
            mem[wr_ptr] <= RegDisplay[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            data     <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                data   <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !accept) begin
                overflow <= 1'b1;
            end
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_display_trace_fifo.sv
// Scoreboard bench for display_trace_fifo with DEPTH=4, DEBOUNCE_CYCLES=4, AUTO_PERIOD=8.
module tb_display_trace_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWrite;
    logic [3:0]  Rd;
    logic [31:0] RegDisplay;
    logic        step_btn;
    logic        auto_mode;
    logic [15:0] data;
    logic [2:0]  count;
    logic        empty;
    logic        overflow;

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] sb [$];
    logic [15:0] exp_data;
    logic        exp_ovf;

    display_trace_fifo #(
        .DEPTH(4), .WATCH_REG(4'd11), .DEBOUNCE_CYCLES(4), .AUTO_PERIOD(8)
    ) dut (
        .clk(clk), .reset(reset), .RegWrite(RegWrite), .Rd(Rd),
        .RegDisplay(RegDisplay), .step_btn(step_btn), .auto_mode(auto_mode),
        .data(data), .count(count), .empty(empty), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        RegWrite = 1'b0;
        step_btn = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        sb.delete();
        exp_data = 16'h0;
        exp_ovf  = 1'b0;
    endtask

    task automatic capture(input logic [3:0] rd, input logic [15:0] v, input logic we = 1'b1);
        RegWrite   = we;
        Rd         = rd;
        RegDisplay = {16'hDEAD, v};
        tick();
        RegWrite   = 1'b0;
        if (we && rd == 4'd11) begin
            if (sb.size() < 4) sb.push_back(v);
            else exp_ovf = 1'b1;
        end
    endtask

    task automatic press();
        step_btn = 1'b1;
        repeat (10) tick();
        step_btn = 1'b0;
        repeat (10) tick();
        if (sb.size() > 0) exp_data = sb.pop_front();
    endtask

    task automatic test_reset();
        do_reset();
        checks += 4;
        if (data !== 16'h0) begin failures++; $display("FAIL reset_data got=%h exp=0000", data); end
        if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
        if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    endtask

    task automatic test_capture();
        capture(4'd11, 16'h1234);
        capture(4'd11, 16'hABCD);
        capture(4'd5, 16'h5555);
        capture(4'd11, 16'h7777, 1'b0);
        checks += 3;
        if (count !== 3'(sb.size())) begin failures++; $display("FAIL capture_count got=%0d exp=%0d", count, sb.size()); end
        if (empty !== 1'b0) begin failures++; $display("FAIL capture_empty got=%b exp=0", empty); end
        if (data !== exp_data) begin failures++; $display("FAIL capture_data got=%h exp=%h", data, exp_data); end
    endtask

    task automatic test_manual();
        press();
        checks += 2;
        if (data !== exp_data) begin failures++; $display("FAIL manual_pop1 got=%h exp=%h", data, exp_data); end
        if (count !== 3'(sb.size())) begin failures++; $display("FAIL manual_count1 got=%0d exp=%0d", count, sb.size()); end
        step_btn = 1'b1;
        tick();
        tick();
        step_btn = 1'b0;
        repeat (12) tick();
        checks += 2;
        if (data !== exp_data) begin failures++; $display("FAIL glitch_data got=%h exp=%h", data, exp_data); end
        if (count !== 3'(sb.size())) begin failures++; $display("FAIL glitch_count got=%0d exp=%0d", count, sb.size()); end
        press();
        checks += 3;
        if (data !== exp_data) begin failures++; $display("FAIL manual_pop2 got=%h exp=%h", data, exp_data); end
        if (count !== 3'd0) begin failures++; $display("FAIL manual_count2 got=%0d exp=0", count); end
        if (empty !== 1'b1) begin failures++; $display("FAIL manual_empty got=%b exp=1", empty); end
        press();
        checks += 1;
        if (data !== exp_data) begin failures++; $display("FAIL manual_empty_hold got=%h exp=%h", data, exp_data); end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 5; i++) capture(4'd11, 16'(i));
        checks += 2;
        if (count !== 3'd4) begin failures++; $display("FAIL ovf_count got=%0d exp=4", count); end
        if (overflow !== exp_ovf) begin failures++; $display("FAIL ovf_flag got=%b exp=%b", overflow, exp_ovf); end
        for (int i = 0; i < 5; i++) begin
            press();
            checks += 2;
            if (data !== exp_data) begin failures++; $display("FAIL ovf_pop%0d got=%h exp=%h", i, data, exp_data); end
            if (count !== 3'(sb.size())) begin failures++; $display("FAIL ovf_popcnt%0d got=%0d exp=%0d", i, count, sb.size()); end
        end
        checks += 1;
        if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) capture(4'd11, 16'h0A00 + 16'(i));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete();
        exp_data = 16'h0;
        exp_ovf  = 1'b0;
        checks += 4;
        if (data !== 16'h0) begin failures++; $display("FAIL midreset_data got=%h exp=0000", data); end
        if (count !== 3'd0) begin failures++; $display("FAIL midreset_count got=%0d exp=0", count); end
        if (empty !== 1'b1) begin failures++; $display("FAIL midreset_empty got=%b exp=1", empty); end
        if (overflow !== 1'b0) begin failures++; $display("FAIL midreset_overflow got=%b exp=0", overflow); end
        capture(4'd11, 16'h0077);
        press();
        checks += 2;
        if (data !== exp_data) begin failures++; $display("FAIL midreset_pop got=%h exp=%h", data, exp_data); end
        if (count !== 3'd0) begin failures++; $display("FAIL midreset_popcnt got=%0d exp=0", count); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int i = 0; i < 4; i++) capture(4'd11, 16'h0041 + 16'(i));
        // Debounced rise fires on the 6th edge after the button goes high.
        step_btn = 1'b1;
        repeat (5) tick();
        RegWrite   = 1'b1;
        Rd         = 4'd11;
        RegDisplay = 32'h0000_0009;
        tick();
        RegWrite = 1'b0;
        exp_data = sb.pop_front();
        sb.push_back(16'h0009);
        checks += 3;
        if (data !== exp_data) begin failures++; $display("FAIL simul_data got=%h exp=%h", data, exp_data); end
        if (count !== 3'd4) begin failures++; $display("FAIL simul_count got=%0d exp=4", count); end
        if (overflow !== 1'b0) begin failures++; $display("FAIL simul_overflow got=%b exp=0", overflow); end
        step_btn = 1'b0;
        repeat (10) tick();
        for (int i = 0; i < 4; i++) begin
            press();
            checks += 1;
            if (data !== exp_data) begin failures++; $display("FAIL simul_drain%0d got=%h exp=%h", i, data, exp_data); end
        end
    endtask

    task automatic test_auto();
        int          changes;
        int          last_at;
        logic [15:0] prev;
        do_reset();
        capture(4'd11, 16'h00A1);
        capture(4'd11, 16'h00A2);
        capture(4'd11, 16'h00A3);
        auto_mode = 1'b1;
        changes = 0;
        last_at = 0;
        for (int i = 1; i <= 60; i++) begin
            step_btn = (i >= 3 && i < 16);
            prev = data;
            tick();
            if (data !== prev) begin
                changes++;
                checks += 2;
                if (sb.size() > 0) exp_data = sb.pop_front();
                if (data !== exp_data) begin failures++; $display("FAIL auto_data%0d got=%h exp=%h", changes, data, exp_data); end
                if (i - last_at !== (changes == 1 ? 9 : 8)) begin
                    failures++;
                    $display("FAIL auto_interval%0d got=%0d exp=%0d", changes, i - last_at, (changes == 1 ? 9 : 8));
                end
                last_at = i;
            end
        end
        checks += 2;
        if (changes !== 3) begin failures++; $display("FAIL auto_changes got=%0d exp=3", changes); end
        if (count !== 3'd0) begin failures++; $display("FAIL auto_count got=%0d exp=0", count); end
        repeat (5) tick();
        capture(4'd11, 16'h0C0C);
        changes = 0;
        for (int j = 1; j <= 20; j++) begin
            tick();
            if (changes == 0 && data !== exp_data) changes = j;
        end
        if (sb.size() > 0) exp_data = sb.pop_front();
        checks += 2;
        if (changes !== 8) begin failures++; $display("FAIL auto_idle_latency got=%0d exp=8", changes); end
        if (data !== exp_data) begin failures++; $display("FAIL auto_idle_data got=%h exp=%h", data, exp_data); end
        auto_mode = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        RegWrite   = 1'b0;
        Rd         = 4'd0;
        RegDisplay = 32'h0;
        step_btn   = 1'b0;
        auto_mode  = 1'b0;
        exp_data   = 16'h0;
        exp_ovf    = 1'b0;
        test_reset();
        test_capture();
        test_manual();
        test_overflow();
        test_reset_mid();
        test_simultaneous();
        test_auto();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
